// File: rtl/key_debouncer_if.sv
// Raw push-button pins in, debounced levels and press/release pulses out.
interface key_debouncer_if #(
    parameter int unsigned NKEYS = 4
);
    logic [NKEYS-1:0] keysRaw;
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] pressed;
    logic [NKEYS-1:0] released;

    modport master (
        output keysRaw,
        input  keys,
        input  pressed,
        input  released
    );

    modport slave (
        input  keysRaw,
        output keys,
        output pressed,
        output released
    );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-flop synchronizer plus stability counter; a new level is accepted
// only after it has been seen on DEBOUNCE_CYCLES consecutive synchronized samples.
module key_debouncer #(
    parameter int unsigned NKEYS           = 4,
    parameter int unsigned ACTIVE_LOW_IN   = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_BITS        = 18
) (
    input logic           clk,
    input logic           reset,
    key_debouncer_if.slave bus
);
    localparam logic [NKEYS-1:0]    POL_MASK = (ACTIVE_LOW_IN != 0) ? '1 : '0;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0]    norm;
    logic [NKEYS-1:0]    s1;
    logic [NKEYS-1:0]    s2;
    logic [NKEYS-1:0]    key_q;
    logic [NKEYS-1:0]    press_q;
    logic [NKEYS-1:0]    release_q;
    logic [CNT_BITS-1:0] cnt [NKEYS];

    // After normalization 1 always means pressed, whatever the board polarity.
    assign norm = bus.keysRaw ^ POL_MASK;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= norm;
            s2        <= s1;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (s2[i] == key_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_BITS'(1);
                end else begin
                    // Counter clears on acceptance, so pulses cannot repeat next edge.
                    key_q[i]     <= s2[i];
                    cnt[i]       <= '0;
                    press_q[i]   <= s2[i];
                    release_q[i] <= !s2[i];
                end
            end
        end
    end

    assign bus.keys     = key_q;
    assign bus.pressed  = press_q;
    assign bus.released = release_q;
endmodule
